// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit timing and frame helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned TICK_W        = 4;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

  // Index of the final data bit for the selected character length.
  function automatic logic [2:0] last_data_idx(input logic bit8);
    return bit8 ? 3'd7 : 3'd6;
  endfunction

  // Parity over the transmitted data bits; bit 7 does not take part in 7-bit frames.
  function automatic logic parity_bit(input logic [7:0] data, input logic bit8,
                                      input logic odd_n_even);
    logic [7:0] masked;
    masked = data;
    if (!bit8) masked[7] = 1'b0;
    return (^masked) ^ odd_n_even;
  endfunction

endpackage

// File: rtl/uart_tx_async.sv
// UART transmitter: start, 7/8 data bits LSB first, optional parity, one stop bit,
// 16 baud_clock pulses per bit, fed from a holding register or an external FIFO.
module uart_tx_async
  import uart_pkg::*;
#(
  parameter bit TX_FIFO = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       write_tx_byte,
  input  logic [7:0] tx_data,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data_out,
  output logic       fifo_read_n,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_idle,
  output logic       tx_done
);

  tx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        hold_q, hold_d;
  logic              tx_ready_q, tx_ready_d;
  logic              cfg_bit8_q, cfg_bit8_d;
  logic              cfg_par_en_q, cfg_par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_q, tx_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_idle_q, tx_idle_d;
  logic              fifo_read_n_q, fifo_read_n_d;

  logic              data_avail_c;
  logic [7:0]        load_byte_c;
  logic              bit_end_c;

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    cfg_bit8_d    = cfg_bit8_q;
    cfg_par_en_d  = cfg_par_en_q;
    par_bit_d     = par_bit_q;
    tx_d          = tx_q;
    tx_done_d     = 1'b0;
    fifo_read_n_d = 1'b1;

    data_avail_c = TX_FIFO ? !fifo_empty : !tx_ready_q;
    load_byte_c  = TX_FIFO ? fifo_data_out : hold_q;
    bit_end_c    = (tick_q == TICK_LAST);

    // Holding register capture runs regardless of baud_clock; full register drops writes.
    if (!TX_FIFO && write_tx_byte && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    if (baud_clock) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
          if (data_avail_c) begin
            state_d = ST_LOAD;
            if (TX_FIFO) fifo_read_n_d = 1'b0;
          end
        end
        ST_LOAD: begin
          state_d      = ST_START;
          shift_d      = load_byte_c;
          cfg_bit8_d   = bit8;
          cfg_par_en_d = parity_en;
          par_bit_d    = parity_bit(load_byte_c, bit8, odd_n_even);
          tick_d       = '0;
          bit_idx_d    = '0;
          tx_d         = 1'b0;
          if (!TX_FIFO) tx_ready_d = 1'b1;
        end
        ST_START: begin
          tick_d = tick_q + TICK_W'(1);
          if (bit_end_c) begin
            state_d = ST_DATA;
            tx_d    = shift_q[0];
          end
        end
        ST_DATA: begin
          tick_d = tick_q + TICK_W'(1);
          if (bit_end_c) begin
            if (bit_idx_q == last_data_idx(cfg_bit8_q)) begin
              state_d = cfg_par_en_q ? ST_PARITY : ST_STOP;
              tx_d    = cfg_par_en_q ? par_bit_q : 1'b1;
            end else begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
              tx_d      = shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          tick_d = tick_q + TICK_W'(1);
          if (bit_end_c) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end
        ST_STOP: begin
          tick_d = tick_q + TICK_W'(1);
          if (bit_end_c) begin
            state_d   = ST_IDLE;
            tx_done_d = 1'b1;
            tx_d      = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    tx_idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      hold_q        <= '0;
      tx_ready_q    <= 1'b1;
      cfg_bit8_q    <= 1'b1;
      cfg_par_en_q  <= 1'b0;
      par_bit_q     <= 1'b0;
      tx_q          <= 1'b1;
      tx_done_q     <= 1'b0;
      tx_idle_q     <= 1'b1;
      fifo_read_n_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      cfg_bit8_q    <= cfg_bit8_d;
      cfg_par_en_q  <= cfg_par_en_d;
      par_bit_q     <= par_bit_d;
      tx_q          <= tx_d;
      tx_done_q     <= tx_done_d;
      tx_idle_q     <= tx_idle_d;
      fifo_read_n_q <= fifo_read_n_d;
    end
  end

  assign tx          = tx_q;
  assign tx_ready    = tx_ready_q;
  assign tx_idle     = tx_idle_q;
  assign tx_done     = tx_done_q;
  assign fifo_read_n = fifo_read_n_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Directed bench for uart_tx_async: holding-register instance (dut0) and FIFO instance (dut1).
module tb_uart_tx_async;

  localparam int unsigned BAUD_DIV = 4;

  logic       clk;
  logic       reset_n;
  logic       baud_clock;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       write_tx_byte;
  logic [7:0] tx_data;
  logic       fifo_empty;
  logic [7:0] fifo_data_out;

  logic fifo_read_n0, tx0, tx_ready0, tx_idle0, tx_done0;
  logic fifo_read_n1, tx1, tx_ready1, tx_idle1, tx_done1;

  int   n_vec;
  int   n_bad;
  bit   baud_en;
  int   fifo_reads;
  logic [7:0] fifo_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        b8;
    logic        pen;
    logic        odd;
    int          nbits;
    logic [10:0] frame;   // transmit order, left aligned: bit k sent = frame[10-k]
    bit          flip;    // invert config right after the start bit begins
    string       name;
  } vec_t;

  vec_t vecs[6];

  uart_tx_async #(.TX_FIFO(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .write_tx_byte(write_tx_byte), .tx_data(tx_data),
    .fifo_empty(1'b1), .fifo_data_out(8'h00),
    .fifo_read_n(fifo_read_n0), .tx(tx0), .tx_ready(tx_ready0),
    .tx_idle(tx_idle0), .tx_done(tx_done0)
  );

  uart_tx_async #(.TX_FIFO(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .write_tx_byte(write_tx_byte), .tx_data(tx_data),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_read_n(fifo_read_n1), .tx(tx1), .tx_ready(tx_ready1),
    .tx_idle(tx_idle1), .tx_done(tx_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud enable: one clk high every BAUD_DIV clks, changed just after posedge.
  initial begin
    int cnt;
    cnt = 0;
    baud_clock = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % BAUD_DIV;
      baud_clock = baud_en && (cnt == BAUD_DIV - 1);
    end
  end

  // FIFO model: a read strobe seen low pops the next byte, visible after the following edge.
  initial begin
    bit rd;
    fifo_empty    = 1'b1;
    fifo_data_out = 8'h00;
    forever begin
      @(negedge clk);
      rd = (fifo_read_n1 == 1'b0);
      @(posedge clk);
      #1;
      if (rd) begin
        fifo_reads++;
        if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx1 : tx0;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    write_tx_byte = 1'b1;
    tx_data       = d;
    @(negedge clk);
    write_tx_byte = 1'b0;
  endtask

  task automatic wait_bauds(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      while (baud_clock !== 1'b1 && g < 32) begin @(negedge clk); g++; end
      @(negedge clk);
    end
  endtask

  // Follows one frame from its start bit; every bit must hold for exactly 16 baud pulses.
  task automatic check_frame(input bit sel, input logic [10:0] frame, input int nbits,
                             input string name, input bit flip);
    int budget;
    budget = 0;
    while (tx_of(sel) !== 1'b0 && budget < 3000) begin @(negedge clk); budget++; end
    chk({name, " start"}, 32'(tx_of(sel)), 32'd0);
    if (!sel) chk({name, " tx_ready at load"}, 32'(tx_ready0), 32'd1);
    if (flip) begin
      bit8 = ~bit8; parity_en = ~parity_en; odd_n_even = ~odd_n_even;
    end
    for (int k = 0; k < nbits; k++) begin
      logic e;
      bit   ok;
      e  = frame[4'(10 - k)];
      ok = 1'b1;
      for (int j = 0; j < 16; j++) begin
        int g;
        g = 0;
        while (baud_clock !== 1'b1 && g < 32) begin
          if (tx_of(sel) !== e) ok = 1'b0;
          @(negedge clk);
          g++;
        end
        if (tx_of(sel) !== e) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d held 16 ticks at %0b", name, k, e), 32'(ok), 32'd1);
    end
    chk({name, " tx_done pulse"}, 32'(sel ? tx_done1 : tx_done0), 32'd1);
    chk({name, " tx_idle after stop"}, 32'(sel ? tx_idle1 : tx_idle0), 32'd1);
    @(negedge clk);
    chk({name, " tx_done one clk"}, 32'(sel ? tx_done1 : tx_done0), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; fifo_reads = 0;
    baud_en = 1'b1;
    reset_n = 1'b0;
    write_tx_byte = 1'b0; tx_data = 8'h00;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 10, 11'b01010010110, 1'b1, "8N1_A5"};
    vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b0, 10, 11'b01000001010, 1'b0, "7E1_41"};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 11, 11'b01100000011, 1'b0, "8O1_03"};
    vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b0, 11, 11'b01100000001, 1'b0, "8E1_03"};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0,  9, 11'b01111111100, 1'b0, "7N1_FF"};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 10, 11'b00000000110, 1'b0, "7O1_80"};

    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx0), 32'd1);
    chk("reset tx_ready", 32'(tx_ready0), 32'd1);
    chk("reset tx_idle", 32'(tx_idle0), 32'd1);
    chk("reset tx_done", 32'(tx_done0), 32'd0);
    chk("reset fifo_read_n", 32'(fifo_read_n1), 32'd1);
    chk("reset fifo tx_ready", 32'(tx_ready1), 32'd1);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle tx after reset", 32'(tx0), 32'd1);

    foreach (vecs[i]) begin
      bit8 = vecs[i].b8; parity_en = vecs[i].pen; odd_n_even = vecs[i].odd;
      send_byte(vecs[i].data);
      chk({vecs[i].name, " tx_ready after write"}, 32'(tx_ready0), 32'd0);
      check_frame(1'b0, vecs[i].frame, vecs[i].nbits, vecs[i].name, vecs[i].flip);
      repeat (5) @(negedge clk);
    end

    // Second write while the holding register is full is dropped.
    begin
      bit ok;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      chk("dropwrite tx_ready", 32'(tx_ready0), 32'd0);
      check_frame(1'b0, 11'b01000100010, 10, "8N1_11", 1'b0);
      ok = 1'b1;
      repeat (300) begin
        if (tx0 !== 1'b1 || tx_idle0 !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk("dropwrite no second frame", 32'(ok), 32'd1);
      chk("dropwrite tx_ready restored", 32'(tx_ready0), 32'd1);
    end

    // Baud held low freezes the FSM but the holding register still captures.
    begin
      bit ok;
      baud_en = 1'b0;
      repeat (3) @(negedge clk);
      send_byte(8'h3C);
      chk("frozen tx_ready capture", 32'(tx_ready0), 32'd0);
      ok = 1'b1;
      repeat (60) begin
        if (tx0 !== 1'b1 || tx_idle0 !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk("frozen fsm idle", 32'(ok), 32'd1);
      baud_en = 1'b1;
      check_frame(1'b0, 11'b00011110010, 10, "8N1_3C", 1'b0);
    end

    // Reset asserted during data bit 3, then a clean frame.
    begin
      int budget;
      send_byte(8'hF0);
      budget = 0;
      while (tx0 !== 1'b0 && budget < 3000) begin @(negedge clk); budget++; end
      wait_bauds(16 + 3 * 16 + 8);
      chk("midreset bit3 before reset", 32'(tx0), 32'd0);
      #1 reset_n = 1'b0;
      #1;
      chk("midreset tx", 32'(tx0), 32'd1);
      chk("midreset tx_idle", 32'(tx_idle0), 32'd1);
      chk("midreset tx_ready", 32'(tx_ready0), 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      send_byte(8'h0F);
      check_frame(1'b0, 11'b01111000010, 10, "8N1_0F", 1'b0);
    end

    // FIFO source: two queued bytes go out back to back with a 2-baud idle gap.
    begin
      int gap;
      int budget;
      bit ok;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      fifo_reads = 0;
      fifo_q.push_back(8'h55);
      fifo_q.push_back(8'hAA);
      check_frame(1'b1, 11'b01010101010, 10, "fifo_55", 1'b0);
      gap = 0; budget = 0;
      while (tx1 !== 1'b0 && budget < 200) begin
        if (baud_clock === 1'b1) gap++;
        @(negedge clk);
        budget++;
      end
      chk("fifo interframe gap bauds", 32'(gap), 32'd2);
      check_frame(1'b1, 11'b00101010110, 10, "fifo_AA", 1'b0);
      ok = 1'b1;
      repeat (300) begin
        if (tx1 !== 1'b1 || tx_idle1 !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk("fifo empty stays idle", 32'(ok), 32'd1);
      chk("fifo read strobes", 32'(fifo_reads), 32'd2);
      chk("fifo tx_ready constant", 32'(tx_ready1), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
